// File: rtl/dir_input_ctrl_if.sv
// Bundle of the direction controller's input sources (PS/2 bytes, buttons, game tick)
// and its registered direction/queue status outputs.
interface dir_input_ctrl_if #(
   parameter int QUEUE_DEPTH = 4
);
   localparam int CW = $clog2(QUEUE_DEPTH) + 1;

   logic [7:0]    key_data;
   logic          key_valid;
   logic [3:0]    button;
   logic          tick;
   logic [4:0]    direction;
   logic [CW-1:0] queue_count;
   logic          overflow;

   modport master (
      output key_data, key_valid, button, tick,
      input  direction, queue_count, overflow
   );

   modport slave (
      input  key_data, key_valid, button, tick,
      output direction, queue_count, overflow
   );
endinterface

// File: rtl/dir_input_ctrl.sv
// Turns PS/2 arrow keys and debounced push-buttons into a small queue of turns,
// one of which is applied to the one-hot direction on every game tick.
module dir_input_ctrl #(
   parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000,
   parameter int          QUEUE_DEPTH     = 4
) (
   input  logic             clk,
   input  logic             reset,
   dir_input_ctrl_if.slave  bus
);
   localparam int PW = $clog2(QUEUE_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [4:0] DIR_IDLE  = 5'b10000;
   localparam logic [4:0] DIR_UP    = 5'b01000;
   localparam logic [4:0] DIR_RIGHT = 5'b00001;
   localparam logic [4:0] DIR_DOWN  = 5'b00010;
   localparam logic [4:0] DIR_LEFT  = 5'b00100;

   function automatic logic [4:0] opposite_dir(input logic [4:0] d);
      case (d)
         DIR_UP:    opposite_dir = DIR_DOWN;
         DIR_DOWN:  opposite_dir = DIR_UP;
         DIR_LEFT:  opposite_dir = DIR_RIGHT;
         DIR_RIGHT: opposite_dir = DIR_LEFT;
         default:   opposite_dir = DIR_IDLE;
      endcase
   endfunction

   // ---------------- scan-code parser ----------------
   typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} parse_state_t;

   parse_state_t state_reg, state_next;
   logic [4:0]   key_map;
   logic         key_mapped;
   logic         key_req;

   always_comb begin
      key_map    = DIR_IDLE;
      key_mapped = 1'b0;
      case (bus.key_data)
         8'h75: begin key_map = DIR_UP;    key_mapped = 1'b1; end
         8'h74: begin key_map = DIR_RIGHT; key_mapped = 1'b1; end
         8'h72: begin key_map = DIR_DOWN;  key_mapped = 1'b1; end
         8'h6B: begin key_map = DIR_LEFT;  key_mapped = 1'b1; end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_reg <= ST_IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      key_req    = 1'b0;
      if (bus.key_valid) begin
         case (state_reg)
            ST_IDLE: begin
               if (bus.key_data == 8'hE0)      state_next = ST_EXT;
               else if (bus.key_data == 8'hF0) state_next = ST_BRK;
               else                            key_req    = key_mapped;
            end
            ST_EXT: begin
               if (bus.key_data == 8'hF0) begin
                  state_next = ST_EXT_BRK;
               end else begin
                  state_next = ST_IDLE;
                  key_req    = key_mapped;
               end
            end
            // Byte after a break prefix is the released key: swallow it.
            default: state_next = ST_IDLE;
         endcase
      end
   end

   // ---------------- button synchronise + debounce ----------------
   logic [3:0] btn_rise;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_btn
         logic        sync1_reg;
         logic        sync2_reg;
         logic        deb_reg;
         logic [19:0] cnt_reg;

         always_ff @(posedge clk) begin
            if (reset) begin
               sync1_reg <= 1'b0;
               sync2_reg <= 1'b0;
               deb_reg   <= 1'b0;
               cnt_reg   <= '0;
            end else begin
               sync1_reg <= bus.button[gi];
               sync2_reg <= sync1_reg;
               if (sync2_reg == deb_reg) begin
                  cnt_reg <= '0;
               end else if (cnt_reg == DEBOUNCE_CYCLES - 20'd1) begin
                  deb_reg <= sync2_reg;
                  cnt_reg <= '0;
               end else begin
                  cnt_reg <= cnt_reg + 20'd1;
               end
            end
         end

         // Fires in the cycle the debounced level is about to rise, so it pulses once per press.
         assign btn_rise[gi] = sync2_reg && !deb_reg && (cnt_reg == DEBOUNCE_CYCLES - 20'd1);
      end
   endgenerate

   // ---------------- request arbitration ----------------
   logic       req_valid;
   logic [4:0] req_dir;

   always_comb begin
      req_valid = 1'b0;
      req_dir   = DIR_IDLE;
      if (key_req) begin
         req_valid = 1'b1;
         req_dir   = key_map;
      end else if (btn_rise[0]) begin
         req_valid = 1'b1;
         req_dir   = DIR_UP;
      end else if (btn_rise[1]) begin
         req_valid = 1'b1;
         req_dir   = DIR_RIGHT;
      end else if (btn_rise[2]) begin
         req_valid = 1'b1;
         req_dir   = DIR_DOWN;
      end else if (btn_rise[3]) begin
         req_valid = 1'b1;
         req_dir   = DIR_LEFT;
      end
   end

   // ---------------- turn queue ----------------
   logic [4:0]    queue_mem [QUEUE_DEPTH];
   logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic [4:0]    tail_reg;
   logic [4:0]    dir_reg;
   logic          ovf_reg;

   logic [4:0] ref_dir;
   logic       rejected, full, do_push, do_ovf, do_pop;

   // Validate against where the snake will be heading once the queue drains.
   assign ref_dir  = (count_reg != '0) ? tail_reg : dir_reg;
   assign rejected = (ref_dir != DIR_IDLE) &&
                     ((req_dir == ref_dir) || (req_dir == opposite_dir(ref_dir)));
   assign full     = (count_reg == CW'(QUEUE_DEPTH));
   assign do_push  = req_valid && !rejected && !full;
   assign do_ovf   = req_valid && !rejected && full;
   assign do_pop   = bus.tick && (count_reg != '0);

   always_ff @(posedge clk) begin
      if (do_push) queue_mem[wr_ptr_reg] <= req_dir;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         tail_reg   <= DIR_IDLE;
         dir_reg    <= DIR_IDLE;
         ovf_reg    <= 1'b0;
      end else begin
         ovf_reg <= do_ovf;
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
            tail_reg   <= req_dir;
         end
         if (do_pop) begin
            dir_reg    <= queue_mem[rd_ptr_reg];
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign bus.direction   = dir_reg;
   assign bus.queue_count = count_reg;
   assign bus.overflow    = ovf_reg;
endmodule

// File: tb/tb_dir_input_ctrl.sv
// Directed bench for dir_input_ctrl: a queue scoreboard predicts each turn as it is
// requested and is popped on every tick to predict the direction.
module tb_dir_input_ctrl;
   localparam logic [4:0] IDLE  = 5'b10000;
   localparam logic [4:0] UP    = 5'b01000;
   localparam logic [4:0] RIGHT = 5'b00001;
   localparam logic [4:0] DOWN  = 5'b00010;
   localparam logic [4:0] LEFT  = 5'b00100;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dir_input_ctrl_if #(.QUEUE_DEPTH(4)) bus ();

   dir_input_ctrl #(
      .DEBOUNCE_CYCLES(20'd4),
      .QUEUE_DEPTH(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus.slave)
   );

   int passed = 0;
   int failed = 0;
   int total  = 0;

   logic [4:0] exp_q[$];
   logic [4:0] exp_dir;
   bit         exp_ovf;

   function automatic logic [4:0] opp(input logic [4:0] d);
      if (d == UP)    return DOWN;
      if (d == DOWN)  return UP;
      if (d == LEFT)  return RIGHT;
      if (d == RIGHT) return LEFT;
      return IDLE;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard prediction for one request against the pre-edge queue state.
   task automatic model_req(input logic [4:0] d, output bit ovf);
      logic [4:0] ref_d;
      ref_d = (exp_q.size() != 0) ? exp_q[$] : exp_dir;
      ovf   = 1'b0;
      if (!(ref_d != IDLE && (d == ref_d || d == opp(ref_d)))) begin
         if (exp_q.size() == 4) ovf = 1'b1;
         else                   exp_q.push_back(d);
      end
   endtask

   task automatic do_reset(input string tag);
      reset         = 1'b1;
      bus.key_valid = 1'b1;
      bus.key_data  = 8'h75;
      bus.tick      = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset         = 1'b0;
      bus.key_valid = 1'b0;
      bus.tick      = 1'b0;
      exp_q.delete();
      exp_dir = IDLE;
      exp_ovf = 1'b0;
      check({tag, " dir"}, bus.direction, IDLE);
      check({tag, " count"}, bus.queue_count, 0);
      check({tag, " ovf"}, bus.overflow, 0);
   endtask

   task automatic key_byte(input logic [7:0] b);
      bus.key_data  = b;
      bus.key_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.key_valid = 1'b0;
   endtask

   task automatic key_req(input string tag, input logic [7:0] code, input bit ext, input logic [4:0] d);
      bit ov;
      if (ext) key_byte(8'hE0);
      model_req(d, ov);
      exp_ovf = ov;
      key_byte(code);
      check({tag, " count"}, bus.queue_count, exp_q.size());
      check({tag, " ovf"}, bus.overflow, exp_ovf);
   endtask

   task automatic tick_step(input string tag);
      bus.tick = 1'b1;
      if (exp_q.size() != 0) exp_dir = exp_q.pop_front();
      @(posedge clk);
      #1;
      bus.tick = 1'b0;
      check({tag, " dir"}, bus.direction, exp_dir);
      check({tag, " count"}, bus.queue_count, exp_q.size());
   endtask

   task automatic push_tick(input string tag, input logic [7:0] code, input logic [4:0] d);
      int pre;
      bit ov;
      pre = exp_q.size();
      model_req(d, ov);
      if (pre != 0) exp_dir = exp_q.pop_front();
      bus.key_data  = code;
      bus.key_valid = 1'b1;
      bus.tick      = 1'b1;
      @(posedge clk);
      #1;
      bus.key_valid = 1'b0;
      bus.tick      = 1'b0;
      check({tag, " dir"}, bus.direction, exp_dir);
      check({tag, " count"}, bus.queue_count, exp_q.size());
   endtask

   task automatic wait_count(input string tag, input int target, output int n);
      n = 0;
      while (int'(bus.queue_count) != target && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, " reached"}, bus.queue_count, target);
   endtask

   initial begin
      int n;
      bit ov;
      bus.key_data  = 8'h00;
      bus.key_valid = 1'b0;
      bus.button    = 4'b0000;
      bus.tick      = 1'b0;
      reset         = 1'b1;

      do_reset("por");

      // Extended up key, then applied by tick
      key_req("e0_75", 8'h75, 1'b1, UP);
      tick_step("tick_up");

      // Break prefix cut by reset must not swallow the next make code
      key_byte(8'hF0);
      do_reset("mid_brk_reset");
      key_req("after_reset_75", 8'h75, 1'b0, UP);

      // Break code ignored, tick on empty queue leaves direction
      do_reset("brk");
      key_byte(8'hF0);
      key_byte(8'h72);
      check("brk_72 count", bus.queue_count, 0);
      tick_step("brk_tick");
      key_req("make_72", 8'h72, 1'b0, DOWN);
      tick_step("tick_down");

      // Rejection against current direction and against tail
      do_reset("rej");
      key_req("rej_75", 8'h75, 1'b0, UP);
      tick_step("rej_tick_up");
      key_req("opp_72", 8'h72, 1'b0, DOWN);
      key_req("left_6b", 8'h6B, 1'b0, LEFT);
      key_req("opp_tail_74", 8'h74, 1'b1, RIGHT);
      tick_step("tick_left");
      key_req("dup_6b", 8'h6B, 1'b1, LEFT);

      // Fill queue, opposite rejected, then overflow
      do_reset("fill");
      key_req("fill_up", 8'h75, 1'b0, UP);
      key_req("fill_right", 8'h74, 1'b1, RIGHT);
      key_req("fill_down", 8'h72, 1'b0, DOWN);
      key_req("fill_left", 8'h6B, 1'b1, LEFT);
      key_req("full_opp_74", 8'h74, 1'b0, RIGHT);
      key_req("full_75", 8'h75, 1'b0, UP);
      @(posedge clk);
      #1;
      check("ovf_one_cycle", bus.overflow, 0);
      check("ovf_count", bus.queue_count, 4);
      repeat (4) tick_step("drain");
      key_req("wrap_75", 8'h75, 1'b0, UP);
      tick_step("wrap_tick");

      // Bouncing right button, then held: exactly one request
      for (int i = 0; i < 6; i++) begin
         bus.button = (i % 2 == 0) ? 4'b0010 : 4'b0000;
         @(posedge clk);
         #1;
      end
      check("bounce no push", bus.queue_count, 0);
      bus.button = 4'b0010;
      model_req(RIGHT, ov);
      wait_count("btn_right", exp_q.size(), n);
      check("btn latency", (n >= 5 && n <= 7), 1);
      repeat (10) @(posedge clk);
      #1;
      check("btn no repeat", bus.queue_count, exp_q.size());
      bus.button = 4'b0000;
      repeat (8) @(posedge clk);
      #1;
      tick_step("tick_btn_right");

      // Simultaneous up+right: up wins, right discarded
      bus.button = 4'b0011;
      model_req(UP, ov);
      wait_count("btn_prio", exp_q.size(), n);
      repeat (8) @(posedge clk);
      #1;
      check("btn prio single", bus.queue_count, exp_q.size());
      tick_step("tick_btn_up");
      bus.button = 4'b0000;
      repeat (8) @(posedge clk);
      #1;
      check("btn release no push", bus.queue_count, 0);

      // Push and tick together with one entry queued, then reset
      do_reset("pt");
      key_req("pt_75", 8'h75, 1'b0, UP);
      push_tick("pt_74", 8'h74, RIGHT);
      do_reset("pt_after");

      // Push and tick together into an empty queue
      push_tick("pt_empty", 8'h75, UP);
      tick_step("pt_empty_tick");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not complete");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/dir_input_ctrl.md
DIR_INPUT_CTRL -- requirements
Module: dir_input_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20'd1000000: consecutive stable cycles required to accept a button level; minimum 2.
REQ-002 Parameter QUEUE_DEPTH, default 4: number of pending turns buffered; power of 2, minimum 2.
REQ-003 Port clk  input  1  system clock; all logic on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port key_data  input  8  PS/2 scan-code byte.
REQ-006 Port key_valid  input  1  one-cycle strobe; key_data valid in that cycle.
REQ-007 Port button  input  4  raw asynchronous buttons: [0] up, [1] right, [2] down, [3] left.
REQ-008 Port tick  input  1  one-cycle game-step strobe; consumes one queued turn.
REQ-009 Port direction  output  5  one-hot direction, registered: 10000 idle, 01000 up, 00001 right, 00010 down, 00100 left.
REQ-010 Port queue_count  output  $clog2(QUEUE_DEPTH)+1  number of queued turns, registered.
REQ-011 Port overflow  output  1  one-cycle pulse when an accepted turn is dropped because the queue is full.

Function
REQ-012 Scan-code parser SHALL be a 4-state FSM (IDLE, EXT, BRK, EXT_BRK) advancing only on key_valid.
REQ-013 IDLE: E0 -> EXT; F0 -> BRK; mapped make code -> key request, stay IDLE; any other byte -> stay IDLE.
REQ-014 EXT: F0 -> EXT_BRK; mapped code -> key request, go to IDLE; any other byte -> IDLE.
REQ-015 BRK and EXT_BRK: any byte -> IDLE with no request (break codes ignored).
REQ-016 Map: 75 up, 74 right, 72 down, 6B left, identical with or without E0 prefix.
REQ-017 Each button SHALL pass through a 2-flop synchroniser, then a per-button counter; debounced level updates only after DEBOUNCE_CYCLES consecutive cycles at the new synchronised level; counter clears on any mismatch.
REQ-018 Button request SHALL be a one-cycle pulse on a 0->1 transition of the debounced level; holding produces no repeats.
REQ-019 Simultaneous button requests: priority up > right > down > left; the others are discarded.
REQ-020 Key request and button request in the same cycle: key request is taken, button request discarded.
REQ-021 Reference direction = tail (last queued) entry if queue_count > 0, else current direction.
REQ-022 Request SHALL be rejected (no push, no overflow) if equal to, or the 180-degree opposite of, the reference; no rejection when reference is 10000.
REQ-023 Non-rejected request with queue_count == QUEUE_DEPTH SHALL be dropped and overflow pulsed in the next cycle.
REQ-024 On tick with queue_count > 0: direction <= head entry, head popped, one-cycle latency.
REQ-025 On tick with empty queue: direction unchanged.
REQ-026 Push and tick in the same cycle: pop uses the pre-push head; push is appended; queue_count net unchanged; a push into an empty queue is not applied by that same tick.
REQ-027 Read/write pointers SHALL wrap modulo QUEUE_DEPTH.

Reset
REQ-028 On reset: direction = 10000, queue_count = 0, pointers = 0, overflow = 0, parser = IDLE, debounced levels = 0, counters and synchronisers = 0.
REQ-029 Reset SHALL take priority over key_valid, button and tick in the same cycle; a sequence interrupted mid-prefix (E0/F0) is discarded.
REQ-030 Button held through reset release SHALL produce one request DEBOUNCE_CYCLES+2 cycles later (approx., ±1) after reset deasserts.

Verification (DEBOUNCE_CYCLES=4, QUEUE_DEPTH=4)
REQ-031 After reset, key bytes E0,75 then tick -> queue_count 1 before tick, direction 01000 one cycle after tick.
REQ-032 Bytes F0,72 then tick -> no push, queue_count 0, direction unchanged; following byte 72 -> down queued.
REQ-033 Direction 01000, empty queue, key 72 -> rejected (queue_count 0); key 6B then 74 -> 6B queued, 74 rejected as opposite of tail.
REQ-034 From idle, queue up,right,down,left (4 entries), then key 74 -> rejected as duplicate-of-nothing? no: tail left, 74 opposite -> rejected; then key 75 -> overflow pulses 1 cycle, queue_count stays 4.
REQ-035 button[1] bouncing 1,0,1 each cycle for 6 cycles then held 1 -> exactly one right request, debounced after 4 stable cycles plus 2 sync cycles.
REQ-036 Queue holding one entry, push and tick same cycle -> direction takes old head, queue_count stays 1; reset asserted next cycle -> all outputs return to reset values.
